// File: rtl/fetch_unit_pkg.sv
// Shared ISA constants and the fetch FSM state type.
// The decoder imports the same opcode constants.
package fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side bus of the fetch stage.
// Handshake: a word moves to decode in every cycle where out_valid & out_ready are both 1.
// While out_valid is 1 and out_ready is 0, out_pc/out_instr hold steady. imem_rdata answers imem_req one cycle later.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// Two-entry {pc, instr} FIFO between imem returns and decode.
// A flush drops all entries, including any push in the same cycle.
module fetch_unit_queue
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);
  logic [ADDR_W-1:0]  pc_mem    [2];
  logic [INSTR_W-1:0] instr_mem [2];
  logic               rd_ptr;
  logic               wr_ptr;

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The issue rule upstream must never let a push land on a full queue.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && count == 2'd2));
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, issue to a 1-cycle imem, HALT drain and branch redirect.
// Returned words are buffered in fetch_unit_queue and handed to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      bus,
  output logic              busy,
  output logic              halted,
  output fetch_state_t      dbg_state
);
  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               inflight;
  logic               kill;
  logic               halt_seen;
  logic               redirect_take;
  logic               start_take;
  logic               room;
  logic               push;
  logic               push_halt;
  logic               pop;
  logic               pop_halt;
  logic [1:0]         count;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;

  assign redirect_take = redirect_valid && (state == ST_FETCH || state == ST_DRAIN);
  assign start_take    = start && (state == ST_IDLE || state == ST_HALTED);

  // A word returning in a redirect cycle belongs to the old path and is dropped.
  assign push      = inflight && !kill && (state == ST_FETCH) && !redirect_take;
  assign push_halt = push && (bus.imem_rdata[OPC_MSB:OPC_LSB] == OPC_HALT);

  // Queue slots already promised: stored words plus the one in flight.
  assign room = (count == 2'd0) || (count == 2'd1 && !inflight);

  assign bus.imem_req  = (state == ST_FETCH) && room && !redirect_take && !push_halt;
  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = head_pc;
  assign bus.out_instr = head_instr;

  assign pop      = bus.out_valid && bus.out_ready;
  assign pop_halt = pop && halt_seen && (state == ST_DRAIN) &&
                    (head_instr[OPC_MSB:OPC_LSB] == OPC_HALT);

  assign dbg_state = state;

  fetch_unit_queue #(.ADDR_W(ADDR_W)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (req_pc),
    .push_instr (bus.imem_rdata),
    .pop        (pop),
    .flush      (redirect_take),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= PC_RESET;
      req_pc    <= PC_RESET;
      inflight  <= 1'b0;
      kill      <= 1'b0;
      halt_seen <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      inflight <= bus.imem_req;
      kill     <= 1'b0;
      if (bus.imem_req) begin
        req_pc <= pc;
        pc     <= pc + ADDR_W'(1);
      end
      if (redirect_take) begin
        pc        <= redirect_pc;
        kill      <= inflight;
        halt_seen <= 1'b0;
        state     <= ST_FETCH;
        busy      <= 1'b1;
        halted    <= 1'b0;
      end else if (start_take) begin
        pc        <= start_pc;
        halt_seen <= 1'b0;
        state     <= ST_FETCH;
        busy      <= 1'b1;
        halted    <= 1'b0;
      end else begin
        case (state)
          ST_FETCH: begin
            if (push_halt) begin
              halt_seen <= 1'b1;
              state     <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (pop_halt) begin
              halt_seen <= 1'b0;
              state     <= ST_HALTED;
              busy      <= 1'b0;
              halted    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
